// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear FSM, 10 ms prescaler and BCD min:sec.cs counter.
// Lap state and snapshot registers exist only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       key_ss_en,
    input  logic       key_lc_en,
    output logic [1:0] state_o,
    output logic       tick_10ms,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       ovf
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] MIN_LAST = 8'((MIN_MAX / 10) * 16 + MIN_MAX % 10);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic [7:0]    cs, sec, mins;
    logic          counting, wrap, clear;
    logic [23:0]   live, shown;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        return (v == last) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;

    // key_ss_en is tested first everywhere so it wins over a simultaneous key_lc_en
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = key_ss_en ? RUN : IDLE;
`ifdef STOPWATCH_LAP_EN
            RUN:     state_nxt = key_ss_en ? PAUSE : key_lc_en ? LAP : RUN;
            LAP:     state_nxt = key_ss_en ? PAUSE : key_lc_en ? RUN : LAP;
`else
            RUN:     state_nxt = key_ss_en ? PAUSE : RUN;
`endif
            PAUSE:   state_nxt = key_ss_en ? RUN : key_lc_en ? IDLE : PAUSE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clear = state == PAUSE && key_lc_en && !key_ss_en;
`ifdef STOPWATCH_LAP_EN
        counting = state == RUN || state == LAP;
`else
        counting = state == RUN;
`endif
        wrap = counting && presc == PRE_LAST;
    end

    assign state_o = state;
    assign live    = {mins, sec, cs};

    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n)                   presc <= '0;
        else if (state == IDLE || clear)  presc <= '0;
        else if (counting)                presc <= wrap ? '0 : presc + PW'(1);

    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            tick_10ms <= 1'b0;
            cs        <= 8'h00;
            sec       <= 8'h00;
            mins      <= 8'h00;
            ovf       <= 1'b0;
        end else begin
            tick_10ms <= wrap;
            if (clear) begin
                cs   <= 8'h00;
                sec  <= 8'h00;
                mins <= 8'h00;
                ovf  <= 1'b0;
            end else if (wrap) begin
                cs <= bcd_inc(cs, 8'h99);
                if (cs == 8'h99) sec <= bcd_inc(sec, 8'h59);
                if (cs == 8'h99 && sec == 8'h59) mins <= bcd_inc(mins, MIN_LAST);
                if (cs == 8'h99 && sec == 8'h59 && mins == MIN_LAST) ovf <= 1'b1;
            end
        end

`ifdef STOPWATCH_LAP_EN
    logic [23:0] snap;

    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n)                                       snap <= '0;
        else if (state == RUN && key_lc_en && !key_ss_en)     snap <= live;

    assign shown = state == LAP ? snap : live;
`else
    assign shown = live;
`endif

    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n) {min_bcd, sec_bcd, cs_bcd} <= '0;
        else            {min_bcd, sec_bcd, cs_bcd} <= shown;
endmodule
